// File: rtl/serial_subtractor_15bits.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin, computed as a + ~b + ~bin
// one DIGIT_BITS slice per clock, LSB digit first, with valid/ready handshakes on both sides.
module serial_subtractor_15bits #(
    parameter int WIDTH      = 15,
    parameter int DIGIT_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             OF
);

    localparam int N  = WIDTH / DIGIT_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    generate
        if (WIDTH % DIGIT_BITS != 0) begin : g_badDigitBits
            $error("serial_subtractor_15bits: WIDTH must be a multiple of DIGIT_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_carry;
    logic [CW-1:0]       r_count;
    logic [WIDTH-1:0]    r_diff;
    logic                r_bout;
    logic                r_of;

    logic [DIGIT_BITS:0] w_sum;
    logic                w_cMsb;
    logic [WIDTH-1:0]    w_diffNext;

    assign w_sum = {1'b0, r_a[DIGIT_BITS-1:0]} + {1'b0, r_b[DIGIT_BITS-1:0]}
                 + {{DIGIT_BITS{1'b0}}, r_carry};

    // Carry into the top bit of the digit, recovered from that bit's sum = a ^ b ^ cin.
    assign w_cMsb = w_sum[DIGIT_BITS-1] ^ r_a[DIGIT_BITS-1] ^ r_b[DIGIT_BITS-1];

    generate
        if (DIGIT_BITS == WIDTH) begin : g_singleDigit
            assign w_diffNext = w_sum[DIGIT_BITS-1:0];
        end else begin : g_multiDigit
            assign w_diffNext = {w_sum[DIGIT_BITS-1:0], r_diff[WIDTH-1:DIGIT_BITS]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= ~b;
                        r_carry <= ~bin;
                        r_count <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT_BITS;
                    r_b     <= r_b >> DIGIT_BITS;
                    r_carry <= w_sum[DIGIT_BITS];
                    r_diff  <= w_diffNext;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST_DIGIT) begin
                        r_bout  <= ~w_sum[DIGIT_BITS];
                        r_of    <= w_cMsb ^ w_sum[DIGIT_BITS];
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign OF        = r_of;

endmodule

// File: tb/tb_serial_subtractor_15bits.sv
// Table-driven bench for serial_subtractor_15bits plus directed back-pressure and reset-abort sequences.
module tb_serial_subtractor_15bits;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] a;
    logic [14:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] diff;
    logic        bout;
    logic        OF;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [14:0] a;
        logic [14:0] b;
        logic        bin;
        logic [14:0] expDiff;
        logic        expBout;
        logic        expOf;
    } vector_t;

    vector_t vecs[9];

    serial_subtractor_15bits dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .OF       (OF)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called right after a negedge: present operands, let the next posedge accept them, then scramble the bus.
    task automatic applyStimulus(input logic [14:0] va, input logic [14:0] vb, input logic vbin);
        checkOutput("in_ready before accept", {31'b0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        bin      = vbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~va;
        b        = va ^ vb;
        bin      = ~vbin;
    endtask

    // Counts posedges after acceptance until out_valid is seen at a negedge; bounded.
    task automatic waitResult(input string name);
        int cycles;
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!out_valid && cycles < 40);
        checkOutput({name, " latency"}, cycles, 32'd15);
    endtask

    task automatic checkResult(input string name, input vector_t v);
        checkOutput({name, " diff"}, {17'b0, diff}, {17'b0, v.expDiff});
        checkOutput({name, " bout"}, {31'b0, bout}, {31'b0, v.expBout});
        checkOutput({name, " OF"},   {31'b0, OF},   {31'b0, v.expOf});
    endtask

    task automatic drainResult(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " out_valid after accept"}, {31'b0, out_valid}, 32'd0);
        checkOutput({name, " in_ready after accept"},  {31'b0, in_ready},  32'd1);
    endtask

    initial begin
        vector_t v;

        vecs[0] = '{15'h0200, 15'h0200, 1'b0, 15'h0000, 1'b0, 1'b0};
        vecs[1] = '{15'h0000, 15'h0001, 1'b0, 15'h7FFF, 1'b1, 1'b0};
        vecs[2] = '{15'h4000, 15'h0001, 1'b0, 15'h3FFF, 1'b0, 1'b1};
        vecs[3] = '{15'h3FFF, 15'h7FFF, 1'b0, 15'h4000, 1'b1, 1'b1};
        vecs[4] = '{15'h0005, 15'h0002, 1'b1, 15'h0002, 1'b0, 1'b0};
        vecs[5] = '{15'h1234, 15'h1234, 1'b1, 15'h7FFF, 1'b1, 1'b0};
        vecs[6] = '{15'h1000, 15'h0234, 1'b0, 15'h0DCC, 1'b0, 1'b0};
        vecs[7] = '{15'h2000, 15'h6000, 1'b0, 15'h4000, 1'b1, 1'b1};
        vecs[8] = '{15'h7FFF, 15'h0001, 1'b0, 15'h7FFE, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset diff",      {17'b0, diff},      32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            string name;
            name = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin);
            waitResult(name);
            checkResult(name, vecs[i]);
            drainResult(name);
        end

        // Back-pressure in DONE while new operands wait on the input side.
        applyStimulus(15'h0005, 15'h0002, 1'b1);
        waitResult("hold first");
        a        = 15'h0000;
        b        = 15'h0001;
        bin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkResult("hold", vecs[4]);
            checkOutput("hold in_ready",  {31'b0, in_ready},  32'd0);
            checkOutput("hold out_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("hold idle in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("hold idle out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 15'h5555;
        b        = 15'h2AAA;
        bin      = 1'b1;
        waitResult("hold second");
        checkResult("hold second", vecs[1]);
        drainResult("hold second");

        // Reset seven cycles into RUN aborts the op and clears the result immediately.
        applyStimulus(15'h1234, 15'h0001, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort in_ready",  {31'b0, in_ready},  32'd1);
        v = '{15'h0000, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0};
        checkResult("abort", v);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort no result", {31'b0, out_valid}, 32'd0);
        applyStimulus(15'h7FFF, 15'h0001, 1'b0);
        waitResult("after abort");
        checkResult("after abort", vecs[8]);
        drainResult("after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
